// File: rtl/conv_result_tx_pkg.sv
// Shared constants, FSM state type and saturation helper for the convolution result transmitter.
package conv_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned GROUP = 4;

    typedef enum logic {IDLE, BURST} tx_state_e;

    function automatic logic [PIX_W-1:0] sat8(input logic signed [63:0] v);
        if (v > 64'sd127)
            return 8'h7F;
        else if (v < -64'sd128)
            return 8'h80;
        else
            return v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/conv_result_tx_fifo.sv
// Synchronous FIFO with registered occupancy count and an align-to-write-pointer flush.
module conv_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr_ok;

    // A write into a full FIFO is legal when the same cycle also pops.
    assign w_wr_ok   = i_wr_en && ((r_count != (AW+1)'(DEPTH)) || i_rd_en);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_flush) begin
                // Discard everything committed; a same-cycle write survives as the only entry.
                r_rd_ptr <= r_wr_ptr;
                r_count  <= (AW+1)'(w_wr_ok);
            end else begin
                if (i_rd_en)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_wr_ok, i_rd_en})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: rtl/conv_result_tx.sv
// Saturating, grouping serial transmitter of convolution results towards pooling.
// Optional CONV_TX_STATS_EN adds group and saturation counters.
module conv_result_tx
    import conv_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_valid_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic             acc_ready_o,
    input  logic             flush_i,
    output logic [7:0]       conv_result_o,
    output logic             en_o,
    output logic             busy_o
`ifdef CONV_TX_STATS_EN
    ,
    output logic [15:0]      grp_cnt_o,
    output logic [15:0]      sat_cnt_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    tx_state_e          r_state;
    logic [1:0]         r_beat;
    logic [PIX_W-1:0]   r_out;
    logic               r_en;
    logic               r_flush_pend;

    logic signed [ACC_W-1:0] w_acc_s;
    logic signed [63:0]      w_acc_ext;
    logic [PIX_W-1:0]        w_sat;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;
    logic [PIX_W-1:0]        w_rd_data;
    logic [CW-1:0]           w_count;

    assign w_acc_s   = acc_i;
    assign w_acc_ext = 64'(w_acc_s);
    assign w_sat     = sat8(w_acc_ext);

    assign acc_ready_o = (w_count != CW'(DEPTH));
    assign w_push      = acc_valid_i && acc_ready_o;
    assign w_pop       = (r_state == BURST);
    assign w_flush     = (r_state == IDLE) && (w_count < CW'(GROUP)) && (flush_i || r_flush_pend);

    conv_tx_fifo #(
        .WIDTH(PIX_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_sat),
        .i_rd_en   (w_pop),
        .i_flush   (w_flush),
        .o_rd_data (w_rd_data),
        .o_count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_out        <= '0;
            r_en         <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_out        <= '0;
                    r_beat       <= '0;
                    // A pending flush gets exactly one IDLE cycle to apply, otherwise it lapses.
                    r_flush_pend <= 1'b0;
                    if (w_count >= CW'(GROUP))
                        r_state <= BURST;
                end
                BURST: begin
                    r_out  <= w_rd_data;
                    r_beat <= r_beat + 2'd1;
                    if (flush_i)
                        r_flush_pend <= 1'b1;
                    if (r_beat == 2'd3) begin
                        r_en <= 1'b1;
                        // Count still includes the entry popped this cycle.
                        if ((w_count - CW'(1)) < CW'(GROUP))
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign conv_result_o = r_out;
    assign en_o          = r_en;
    assign busy_o        = (r_state == BURST) || (w_count != '0);

`ifdef CONV_TX_STATS_EN
    logic [15:0] r_grp_cnt;
    logic [15:0] r_sat_cnt;
    logic        w_is_sat;

    assign w_is_sat = (w_acc_ext > 64'sd127) || (w_acc_ext < -64'sd128);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grp_cnt <= '0;
            r_sat_cnt <= '0;
        end else begin
            if ((r_state == BURST) && (r_beat == 2'd3))
                r_grp_cnt <= r_grp_cnt + 16'd1;
            if (w_push && w_is_sat)
                r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign grp_cnt_o = r_grp_cnt;
    assign sat_cnt_o = r_sat_cnt;
`endif

endmodule

// File: tb/tb_conv_result_tx.sv
// Directed self-checking bench for conv_result_tx, plus a standalone FIFO instance for full-boundary cases.
module tb_conv_result_tx;

    logic        clk;
    logic        rst;
    logic        acc_valid_i;
    logic [15:0] acc_i;
    logic        acc_ready_o;
    logic        flush_i;
    logic [7:0]  conv_result_o;
    logic        en_o;
    logic        busy_o;
`ifdef CONV_TX_STATS_EN
    logic [15:0] grp_cnt_o;
    logic [15:0] sat_cnt_o;
`endif

    logic        f_wr;
    logic        f_rd;
    logic        f_flush;
    logic [7:0]  f_wdata;
    logic [7:0]  f_rdata;
    logic [4:0]  f_count;

    int unsigned checks;
    int unsigned failures;

    conv_result_tx #(
        .ACC_W(16),
        .DEPTH(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .acc_valid_i   (acc_valid_i),
        .acc_i         (acc_i),
        .acc_ready_o   (acc_ready_o),
        .flush_i       (flush_i),
        .conv_result_o (conv_result_o),
        .en_o          (en_o),
        .busy_o        (busy_o)
`ifdef CONV_TX_STATS_EN
        ,
        .grp_cnt_o     (grp_cnt_o),
        .sat_cnt_o     (sat_cnt_o)
`endif
    );

    conv_tx_fifo #(
        .WIDTH(8),
        .DEPTH(16)
    ) fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (f_wr),
        .i_wr_data (f_wdata),
        .i_rd_en   (f_rd),
        .i_flush   (f_flush),
        .o_rd_data (f_rdata),
        .o_count   (f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        acc_valid_i = 1'b1;
        acc_i       = v;
        tick();
        acc_valid_i = 1'b0;
        acc_i       = '0;
    endtask

    // Called right after the 4th push edge: one IDLE cycle, four bytes, then back to zero.
    task automatic check_group(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp_b [4];
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        tick();
        chk({tag, "_start_out"}, 32'(conv_result_o), 32'h0);
        chk({tag, "_start_en"}, 32'(en_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_byte%0d", tag, i), 32'(conv_result_o), 32'(exp_b[i]));
            chk($sformatf("%s_en%0d", tag, i), 32'(en_o), (i == 3) ? 32'h1 : 32'h0);
        end
        tick();
        chk({tag, "_end_out"}, 32'(conv_result_o), 32'h0);
        chk({tag, "_end_en"}, 32'(en_o), 32'h0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        acc_valid_i = 1'b0;
        acc_i       = '0;
        flush_i     = 1'b0;
        f_wr        = 1'b0;
        f_rd        = 1'b0;
        f_flush     = 1'b0;
        f_wdata     = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_out", 32'(conv_result_o), 32'h0);
        chk("rst_en", 32'(en_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(acc_ready_o), 32'h1);

        // Basic group
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        chk("g1_busy", 32'(busy_o), 32'h1);
        check_group("g1", 8'h01, 8'h02, 8'h03, 8'h04);
        chk("g1_idle_busy", 32'(busy_o), 32'h0);

        // Saturation
        push(16'd300); push(-16'sd300); push(16'd127); push(-16'sd128);
        check_group("sat", 8'h7F, 8'h80, 8'h7F, 8'h80);
`ifdef CONV_TX_STATS_EN
        chk("sat_cnt", 32'(sat_cnt_o), 32'd2);
        chk("grp_cnt", 32'(grp_cnt_o), 32'd2);
`endif

        // Back-to-back stream of 8 with valid held
        for (int k = 1; k <= 14; k++) begin
            acc_valid_i = (k <= 8);
            acc_i       = 16'(15 + k);
            tick();
            chk($sformatf("strm_out%0d", k), 32'(conv_result_o),
                (k >= 6 && k <= 13) ? 32'(16 + k - 6) : 32'h0);
            chk($sformatf("strm_en%0d", k), 32'(en_o), (k == 9 || k == 13) ? 32'h1 : 32'h0);
            if (k <= 8)
                chk($sformatf("strm_ready%0d", k), 32'(acc_ready_o), 32'h1);
        end
        acc_valid_i = 1'b0;
        acc_i       = '0;

        // Flush of a partial group
        push(16'h21); push(16'h22); push(16'h23);
        chk("fl_busy_pre", 32'(busy_o), 32'h1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_busy", 32'(busy_o), 32'h0);
        chk("fl_out", 32'(conv_result_o), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_quiet_en%0d", k), 32'(en_o), 32'h0);
        end
        push(16'h31); push(16'h32); push(16'h33); push(16'h34);
        check_group("fl_grp", 8'h31, 8'h32, 8'h33, 8'h34);

        // Flush with a simultaneous push keeps only the new entry
        push(16'h35); push(16'h36);
        flush_i = 1'b1;
        push(16'h40);
        flush_i = 1'b0;
        chk("flp_busy", 32'(busy_o), 32'h1);
        push(16'h41); push(16'h42); push(16'h43);
        check_group("flp_grp", 8'h40, 8'h41, 8'h42, 8'h43);

        // Reset during beat 2
        push(16'h51); push(16'h52); push(16'h53); push(16'h54);
        tick();
        tick();
        chk("rb_b0", 32'(conv_result_o), 32'h51);
        tick();
        chk("rb_b1", 32'(conv_result_o), 32'h52);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_out", 32'(conv_result_o), 32'h0);
        chk("rb_en", 32'(en_o), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rb_quiet_en%0d", k), 32'(en_o), 32'h0);
            chk($sformatf("rb_quiet_out%0d", k), 32'(conv_result_o), 32'h0);
        end
        chk("rb_busy", 32'(busy_o), 32'h0);
        chk("rb_ready", 32'(acc_ready_o), 32'h1);

        // FIFO full boundary on a standalone instance
        for (int i = 0; i < 16; i++) begin
            f_wr    = 1'b1;
            f_wdata = 8'(8'hA0 + i);
            tick();
        end
        f_wr = 1'b0;
        chk("ff_count_full", 32'(f_count), 32'd16);
        chk("ff_head", 32'(f_rdata), 32'hA0);
        f_wr    = 1'b1;
        f_wdata = 8'hEE;
        tick();
        chk("ff_overflow_ignored", 32'(f_count), 32'd16);
        f_rd    = 1'b1;
        f_wdata = 8'hB0;
        tick();
        f_wr = 1'b0;
        f_rd = 1'b0;
        chk("ff_pushpop_count", 32'(f_count), 32'd16);
        chk("ff_pushpop_head", 32'(f_rdata), 32'hA1);
        f_rd = 1'b1;
        for (int i = 0; i < 15; i++)
            tick();
        f_rd = 1'b0;
        chk("ff_wrap_tail", 32'(f_rdata), 32'hB0);
        chk("ff_wrap_count", 32'(f_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
